// File: rtl/riscv_csr_pkg.sv
// Shared CSR-side definitions for the machine-mode interrupt controller:
// XLEN, controller defaults, FSM state encoding and the mcause helper.
package riscv_csr_pkg;

    localparam int MXLEN              = 32;
    localparam int IRQ_NUM_DEFAULT    = 16;
    localparam int CAUSE_BASE_DEFAULT = 16;
    localparam int IRQ_IDX_W          = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TRAP    = 2'd1,
        ST_HANDLER = 2'd2,
        ST_RETURN  = 2'd3
    } irq_state_t;

    // Interrupt causes carry the MSB set; the low bits hold the exception code.
    function automatic logic [MXLEN-1:0] irq_mcause(input logic [MXLEN-1:0] code);
        return {1'b1, code[MXLEN-2:0]};
    endfunction

endpackage

// File: rtl/riscv_irq_prio.sv
// Combinational lowest-index priority encoder over the enabled pending lines.
module riscv_irq_prio
    import riscv_csr_pkg::*;
#(
    parameter int N = IRQ_NUM_DEFAULT
) (
    input  logic [N-1:0]           req_i,
    output logic                   valid_o,
    output logic [IRQ_IDX_W-1:0]   idx_o
);

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                valid_o = 1'b1;
                idx_o   = IRQ_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/riscv_irq_ctrl.sv
// Machine-mode external interrupt controller: edge capture, pending tracking,
// trap entry with direct/vectored mtvec, and mret return redirect.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | waiting for an enabled pending line and an instruction boundary
// ST_TRAP    | one cycle: trap pulse, acknowledge, redirect to the handler
// ST_HANDLER | handler running; no nesting, pending lines keep accumulating
// ST_RETURN  | one cycle: redirect to mepc after mret
module riscv_irq_ctrl
    import riscv_csr_pkg::*;
#(
    parameter int IRQ_NUM    = IRQ_NUM_DEFAULT,
    parameter int CAUSE_BASE = CAUSE_BASE_DEFAULT
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic [IRQ_NUM-1:0]   irq_i,
    input  logic [MXLEN-1:0]     mie_i,
    input  logic [MXLEN-1:0]     mtvec_i,
    input  logic [MXLEN-1:0]     mepc_i,
    input  logic                 ready_i,
    input  logic                 mret_i,
    output logic                 trap_o,
    output logic [MXLEN-1:0]     mcause_o,
    output logic                 redirect_o,
    output logic [MXLEN-1:0]     target_o,
    output logic [IRQ_NUM-1:0]   irq_ack_o
);

    irq_state_t             state_q, state_d;
    logic [IRQ_NUM-1:0]     sync_q, prev_q;
    logic [IRQ_NUM-1:0]     pend_q, pend_d;
    logic [IRQ_NUM-1:0]     rise;
    logic [IRQ_NUM-1:0]     pend_en;
    logic [1:0]             arm_q;
    logic [IRQ_IDX_W-1:0]   idx_q, idx_d;
    logic [MXLEN-1:0]       mcause_q, mcause_d;
    logic                   prio_valid;
    logic [IRQ_IDX_W-1:0]   prio_idx;
    logic [MXLEN-1:0]       new_code, trap_code, tvec_base, tvec_target;
    logic                   mie_unused;

    // Edge detection stays disarmed until sync_q and prev_q both hold real
    // samples, so a line already high at reset release is not an edge.
    assign rise    = arm_q[1] ? (sync_q & ~prev_q) : '0;
    assign pend_en = pend_q & mie_i[CAUSE_BASE +: IRQ_NUM];

    riscv_irq_prio #(.N(IRQ_NUM)) u_prio (
        .req_i   (pend_en),
        .valid_o (prio_valid),
        .idx_o   (prio_idx)
    );

    assign new_code    = MXLEN'(CAUSE_BASE) + MXLEN'(prio_idx);
    assign trap_code   = MXLEN'(CAUSE_BASE) + MXLEN'(idx_q);
    assign tvec_base   = {mtvec_i[MXLEN-1:2], 2'b00};
    assign tvec_target = (mtvec_i[1:0] == 2'b01) ? tvec_base + (trap_code << 2) : tvec_base;
    assign mcause_o    = mcause_q;
    assign mie_unused  = ^mie_i;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q  <= ST_IDLE;
            sync_q   <= '0;
            prev_q   <= '0;
            arm_q    <= '0;
            pend_q   <= '0;
            idx_q    <= '0;
            mcause_q <= '0;
        end else begin
            state_q  <= state_d;
            sync_q   <= irq_i;
            prev_q   <= sync_q;
            arm_q    <= {arm_q[0], 1'b1};
            pend_q   <= pend_d;
            idx_q    <= idx_d;
            mcause_q <= mcause_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        mcause_d   = mcause_q;
        trap_o     = 1'b0;
        redirect_o = 1'b0;
        irq_ack_o  = '0;
        target_o   = '0;
        case (state_q)
            ST_IDLE: begin
                if (prio_valid && ready_i) begin
                    state_d  = ST_TRAP;
                    idx_d    = prio_idx;
                    mcause_d = irq_mcause(new_code);
                end
            end
            ST_TRAP: begin
                trap_o     = 1'b1;
                redirect_o = 1'b1;
                irq_ack_o  = IRQ_NUM'(1) << idx_q;
                target_o   = tvec_target;
                state_d    = ST_HANDLER;
            end
            ST_HANDLER: begin
                if (mret_i) state_d = ST_RETURN;
            end
            ST_RETURN: begin
                redirect_o = 1'b1;
                target_o   = mepc_i;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // A fresh edge in the acknowledge cycle survives the clear.
        pend_d = (pend_q & ~irq_ack_o) | rise;
    end

endmodule

// File: doc/riscv_irq_ctrl.md
RISCV_IRQ_CTRL -- requirements
Module: riscv_irq_ctrl

Interface
REQ-001 SHALL have parameter IRQ_NUM, default 16, meaning number of external interrupt lines (1..16).
REQ-002 SHALL have parameter CAUSE_BASE, default 16, meaning mcause code of line 0 (line n -> CAUSE_BASE+n).
REQ-003 SHALL have port clk_i  input  1  core clock; one clock domain.
REQ-004 SHALL have port rstn_i  input  1  core reset, synchronous, active-low.
REQ-005 SHALL have port irq_i  input  IRQ_NUM  external interrupt lines, rising-edge sensitive.
REQ-006 SHALL have port mie_i  input  MXLEN  CSR mie value; bit CAUSE_BASE+n enables line n.
REQ-007 SHALL have port mtvec_i  input  MXLEN  CSR mtvec value.
REQ-008 SHALL have port mepc_i  input  MXLEN  CSR mepc value.
REQ-009 SHALL have port ready_i  input  1  core can accept a trap this cycle (instruction boundary).
REQ-010 SHALL have port mret_i  input  1  one-cycle pulse, mret executed.
REQ-011 SHALL have port trap_o  output  1  one-cycle pulse to CSR trap_i.
REQ-012 SHALL have port mcause_o  output  MXLEN  cause value to CSR mcause_i.
REQ-013 SHALL have port redirect_o  output  1  one-cycle PC redirect strobe to fetch.
REQ-014 SHALL have port target_o  output  MXLEN  redirect PC, valid when redirect_o=1.
REQ-015 SHALL have port irq_ack_o  output  IRQ_NUM  one-hot acknowledge, pulses with trap_o.

Function
REQ-016 SHALL register irq_i once, set pend[n] on a 0->1 transition of irq_i[n], and hold pend[n] until acknowledged.
REQ-017 SHALL implement FSM IDLE, TRAP, HANDLER, RETURN.
REQ-018 In IDLE, SHALL go to TRAP when (pend & mie_i[CAUSE_BASE+IRQ_NUM-1:CAUSE_BASE]) != 0 and ready_i=1; else stay IDLE.
REQ-019 SHALL select the lowest-indexed enabled pending line, idx, in the IDLE->TRAP transition cycle and latch it.
REQ-020 In TRAP (exactly one cycle), SHALL assert trap_o=1, redirect_o=1, irq_ack_o[idx]=1, clear pend[idx], and go to HANDLER.
REQ-021 SHALL drive mcause_o = {1'b1, (MXLEN-1)-bit CAUSE_BASE+idx} registered; value held until next trap.
REQ-022 target_o in TRAP SHALL be base = {mtvec_i[MXLEN-1:2],2'b00} if mtvec_i[1:0]!=2'b01, else base + 4*(CAUSE_BASE+idx), modulo 2^MXLEN.
REQ-023 In HANDLER, SHALL not take further traps (no nesting); pend SHALL keep accumulating; on mret_i=1 go to RETURN.
REQ-024 In RETURN (one cycle), SHALL assert redirect_o=1, target_o=mepc_i, then go to IDLE.
REQ-025 Trap latency SHALL be: edge on irq_i in cycle N -> earliest trap_o in cycle N+3 (sync, pend, TRAP).
REQ-026 mret_i outside HANDLER SHALL be ignored.
REQ-027 New edge on line idx in the same cycle it is acknowledged SHALL leave pend[idx]=1 (set wins).
REQ-028 Clearing the mie bit of a pending line SHALL mask but not clear pend.
REQ-029 ready_i=0 in IDLE SHALL hold off the trap indefinitely with no pending loss.
REQ-030 Outputs other than target_o/mcause_o SHALL be 0 outside TRAP/RETURN as stated.

Reset
REQ-031 On rstn_i=0 at a clock edge, SHALL go to IDLE and clear pend, edge-sync registers, trap_o, redirect_o, irq_ack_o, mcause_o, target_o to 0, regardless of current state.
REQ-032 Line held high through reset release SHALL NOT generate a pending edge.

Structure
REQ-033 SHALL place irq_state_t enum, IRQ_NUM default and CAUSE_BASE default in riscv_csr_pkg, reusing MXLEN.
REQ-034 SHALL use one sub-module riscv_irq_prio (combinational lowest-index priority encoder: valid + index).

Verification
REQ-035 irq_i[3] rises, mie_i=1<<19, mtvec_i=0x0000_0100, ready_i=1 -> trap_o 3 cycles later, mcause_o=0x8000_0013, target_o=0x100, irq_ack_o=0x0008.
REQ-036 Same with mtvec_i=0x0000_0101 -> target_o=0x0000_014C.
REQ-037 irq_i[5] and irq_i[2] rise together, both enabled -> first trap line 2 (mcause 0x8000_0012); after mret_i, RETURN redirect to mepc_i=0x0000_0420, then trap line 5 (0x8000_0015).
REQ-038 Edge on line 1 while in HANDLER -> no trap_o until mret_i; trap follows RETURN-IDLE.
REQ-039 pend line 0 with ready_i=0 for 10 cycles -> no trap; ready_i=1 -> trap next cycle; mie bit cleared -> no trap, re-enabled -> trap.
REQ-040 rstn_i=0 during HANDLER -> next cycle IDLE, all outputs 0, pend empty; held-high irq_i causes no trap.
